// File: rtl/fuzz_iter_sequencer.sv
// Fuzzing iteration controller: watches tohost for pass, enforces the cycle watchdog,
// freezes the DUT, reports coverage, drives memory reload and sequences the core reset.
module fuzz_iter_sequencer #(
  parameter int RESET_HOLD = 10,
  parameter int COV_W      = 64,
  parameter int CNT_W      = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [63:0]      tohost,
  input  logic             fuzz_en,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [COV_W-1:0] cov_sum,
  output logic             core_reset,
  output logic             dut_clk_en,
  output logic             tohost_mask,
  output logic             cov_valid,
  output logic [COV_W-1:0] cov_data,
  input  logic             cov_ready,
  input  logic             cov_reload,
  output logic             load_req,
  input  logic             load_done,
  output logic             pass_pulse,
  output logic             finished,
  output logic             failed,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [31:0]      iter_cnt
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    INIT,
    RUN,
    QUIESCE,
    REPORT,
    LOAD,
    HOLD,
    DONE,
    FAIL
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              timeout;
  logic              run_pass;
  logic              enter_hold;
  logic              unused_tohost_hi;

  // Only bit 0 of tohost carries meaning; the upper bits are deliberately dropped.
  assign unused_tohost_hi = ^tohost[63:1];

  // Timeout is checked before pass so a watchdog expiry wins over a simultaneous pass.
  always_comb begin
    hold_done  = (hold_cnt == HOLD_LAST);
    timeout    = (max_cycles != '0) && (cycle_cnt >= max_cycles);
    run_pass   = (state == RUN) && !timeout && tohost[0];
    enter_hold = (state_next == HOLD) && (state != HOLD);
  end

  always_comb begin
    state_next  = state;
    core_reset  = 1'b0;
    dut_clk_en  = 1'b1;
    tohost_mask = 1'b0;
    cov_valid   = 1'b0;
    load_req    = 1'b0;
    finished    = 1'b0;
    failed      = 1'b0;
    case (state)
      INIT: begin
        core_reset = 1'b1;
        if (hold_done) state_next = RUN;
      end
      HOLD: begin
        core_reset  = 1'b1;
        tohost_mask = 1'b1;
        if (hold_done) state_next = RUN;
      end
      RUN: begin
        if (timeout)        state_next = FAIL;
        else if (tohost[0]) state_next = fuzz_en ? QUIESCE : DONE;
      end
      QUIESCE: begin
        dut_clk_en  = 1'b0;
        tohost_mask = 1'b1;
        state_next  = REPORT;
      end
      REPORT: begin
        dut_clk_en  = 1'b0;
        tohost_mask = 1'b1;
        cov_valid   = 1'b1;
        if (cov_ready) state_next = cov_reload ? LOAD : HOLD;
      end
      LOAD: begin
        core_reset  = 1'b1;
        dut_clk_en  = 1'b0;
        tohost_mask = 1'b1;
        load_req    = 1'b1;
        if (load_done) state_next = HOLD;
      end
      DONE: begin
        dut_clk_en = 1'b0;
        finished   = 1'b1;
      end
      FAIL: begin
        dut_clk_en = 1'b0;
        failed     = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // The reset hold counter only runs in INIT/HOLD and restarts from zero on every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if ((state == INIT) || (state == HOLD)) begin
      hold_cnt <= hold_done ? '0 : hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // cycle_cnt freezes on the timeout edge so FAIL reports the exact expiry count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (enter_hold) begin
      cycle_cnt <= '0;
    end else if ((state == RUN) && !timeout && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      iter_cnt <= '0;
    end else if ((state == HOLD) && hold_done) begin
      iter_cnt <= iter_cnt + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pass_pulse <= 1'b0;
      cov_data   <= '0;
    end else begin
      pass_pulse <= run_pass;
      if (run_pass) cov_data <= cov_sum;
    end
  end

endmodule

// File: tb/tb_fuzz_iter_sequencer.sv
// Directed self-checking bench for fuzz_iter_sequencer with hand-computed expectations.
module tb_fuzz_iter_sequencer;

  localparam int RESET_HOLD = 10;
  localparam int COV_W      = 64;
  localparam int CNT_W      = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic [63:0]      tohost;
  logic             fuzz_en;
  logic [CNT_W-1:0] max_cycles;
  logic [COV_W-1:0] cov_sum;
  logic             core_reset;
  logic             dut_clk_en;
  logic             tohost_mask;
  logic             cov_valid;
  logic [COV_W-1:0] cov_data;
  logic             cov_ready;
  logic             cov_reload;
  logic             load_req;
  logic             load_done;
  logic             pass_pulse;
  logic             finished;
  logic             failed;
  logic [CNT_W-1:0] cycle_cnt;
  logic [31:0]      iter_cnt;

  int numChecks = 0;
  int numFails  = 0;
  int holdCycles;

  fuzz_iter_sequencer #(
    .RESET_HOLD(RESET_HOLD),
    .COV_W(COV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tohost(tohost),
    .fuzz_en(fuzz_en),
    .max_cycles(max_cycles),
    .cov_sum(cov_sum),
    .core_reset(core_reset),
    .dut_clk_en(dut_clk_en),
    .tohost_mask(tohost_mask),
    .cov_valid(cov_valid),
    .cov_data(cov_data),
    .cov_ready(cov_ready),
    .cov_reload(cov_reload),
    .load_req(load_req),
    .load_done(load_done),
    .pass_pulse(pass_pulse),
    .finished(finished),
    .failed(failed),
    .cycle_cnt(cycle_cnt),
    .iter_cnt(iter_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] th, input logic fe, input logic [63:0] mc,
                               input logic [63:0] cs, input logic rdy, input logic rl,
                               input logic ld);
    tohost     = th;
    fuzz_en    = fe;
    max_cycles = mc;
    cov_sum    = cs;
    cov_ready  = rdy;
    cov_reload = rl;
    load_done  = ld;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(64'h0, 1'b0, 64'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    applyReset();

    $display("[TB] reset state");
    checkOutput("rst_core_reset", core_reset, 1);
    checkOutput("rst_clk_en", dut_clk_en, 1);
    checkOutput("rst_mask", tohost_mask, 0);
    checkOutput("rst_cov_valid", cov_valid, 0);
    checkOutput("rst_cov_data", cov_data, 0);
    checkOutput("rst_load_req", load_req, 0);
    checkOutput("rst_pass", pass_pulse, 0);
    checkOutput("rst_finished", finished, 0);
    checkOutput("rst_failed", failed, 0);
    checkOutput("rst_cycle", cycle_cnt, 0);
    checkOutput("rst_iter", iter_cnt, 0);

    tick(RESET_HOLD - 1);
    checkOutput("init_last_hold", core_reset, 1);
    tick(1);
    checkOutput("init_run_core_reset", core_reset, 0);
    checkOutput("init_run_cycle", cycle_cnt, 0);

    $display("[TB] non-fuzz pass");
    tick(49);
    checkOutput("nf_cycle49", cycle_cnt, 49);
    applyStimulus(64'hFFFF_0000_0000_0001, 1'b0, 64'd0, 64'hABCD, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("nf_pass_pulse", pass_pulse, 1);
    checkOutput("nf_finished", finished, 1);
    checkOutput("nf_clk_en", dut_clk_en, 0);
    checkOutput("nf_cycle", cycle_cnt, 50);
    checkOutput("nf_iter", iter_cnt, 0);
    checkOutput("nf_cov_valid", cov_valid, 0);
    tick(1);
    checkOutput("nf_pass_one_cycle", pass_pulse, 0);
    checkOutput("nf_finished_sticky", finished, 1);
    checkOutput("nf_core_reset", core_reset, 0);
    checkOutput("nf_cycle_hold", cycle_cnt, 50);
    checkOutput("nf_no_cov_valid", cov_valid, 0);

    $display("[TB] timeout");
    applyStimulus(64'h0, 1'b0, 64'd100, 64'h0, 1'b0, 1'b0, 1'b0);
    applyReset();
    checkOutput("to_reset_finished", finished, 0);
    tick(RESET_HOLD);
    tick(100);
    checkOutput("to_before_cycle", cycle_cnt, 100);
    checkOutput("to_before_failed", failed, 0);
    tick(1);
    checkOutput("to_failed", failed, 1);
    checkOutput("to_cycle", cycle_cnt, 100);
    tick(3);
    checkOutput("to_cycle_frozen", cycle_cnt, 100);
    checkOutput("to_clk_en", dut_clk_en, 0);
    checkOutput("to_failed_sticky", failed, 1);

    $display("[TB] timeout with simultaneous pass");
    applyReset();
    checkOutput("top_reset_failed", failed, 0);
    tick(RESET_HOLD + 100);
    applyStimulus(64'h1, 1'b1, 64'd100, 64'h77, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("top_failed", failed, 1);
    checkOutput("top_no_pass", pass_pulse, 0);
    checkOutput("top_not_finished", finished, 0);
    checkOutput("top_cycle", cycle_cnt, 100);

    $display("[TB] fuzz reload loop");
    applyStimulus(64'h0, 1'b1, 64'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    applyReset();
    tick(RESET_HOLD + 5);
    checkOutput("fr_cycle5", cycle_cnt, 5);
    applyStimulus(64'h1, 1'b1, 64'd0, 64'h1234, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("fr_q_pass", pass_pulse, 1);
    checkOutput("fr_q_clk_en", dut_clk_en, 0);
    checkOutput("fr_q_mask", tohost_mask, 1);
    checkOutput("fr_q_cov_valid", cov_valid, 0);
    cov_sum = 64'h5555;
    tick(1);
    checkOutput("fr_r_cov_valid", cov_valid, 1);
    checkOutput("fr_r_cov_data", cov_data, 64'h1234);
    checkOutput("fr_r_no_pass", pass_pulse, 0);
    tick(4);
    checkOutput("fr_r_wait_valid", cov_valid, 1);
    checkOutput("fr_r_wait_data", cov_data, 64'h1234);
    checkOutput("fr_r_wait_no_pass", pass_pulse, 0);
    cov_ready  = 1'b1;
    cov_reload = 1'b1;
    tick(1);
    cov_ready = 1'b0;
    checkOutput("fr_l_cov_valid", cov_valid, 0);
    checkOutput("fr_l_load_req", load_req, 1);
    checkOutput("fr_l_core_reset", core_reset, 1);
    checkOutput("fr_l_clk_en", dut_clk_en, 0);
    checkOutput("fr_l_no_pass", pass_pulse, 0);
    tick(3);
    checkOutput("fr_l_wait_load_req", load_req, 1);
    checkOutput("fr_l_wait_no_pass", pass_pulse, 0);
    load_done = 1'b1;
    tohost    = 64'h0;
    tick(1);
    load_done = 1'b0;
    checkOutput("fr_h_load_req", load_req, 0);
    checkOutput("fr_h_clk_en", dut_clk_en, 1);
    checkOutput("fr_h_cycle", cycle_cnt, 0);
    holdCycles = 0;
    while (core_reset && holdCycles < 20) begin
      holdCycles++;
      tick(1);
    end
    checkOutput("fr_hold_len", holdCycles, RESET_HOLD);
    checkOutput("fr_run_cycle", cycle_cnt, 0);
    checkOutput("fr_run_iter", iter_cnt, 1);
    checkOutput("fr_run_mask", tohost_mask, 0);

    load_done = 1'b1;
    tick(1);
    load_done = 1'b0;
    checkOutput("sp_ld_cycle", cycle_cnt, 1);
    checkOutput("sp_ld_core_reset", core_reset, 0);
    checkOutput("sp_ld_load_req", load_req, 0);

    $display("[TB] fuzz no reload");
    applyStimulus(64'h0, 1'b1, 64'd0, 64'h0, 1'b1, 1'b0, 1'b0);
    applyReset();
    tick(RESET_HOLD);
    for (int i = 1; i <= 3; i++) begin
      tick(3);
      tohost  = 64'h1;
      cov_sum = 64'(i) * 64'h100;
      tick(1);
      checkOutput("nr_pass", pass_pulse, 1);
      tohost = 64'h0;
      tick(1);
      checkOutput("nr_cov_valid", cov_valid, 1);
      checkOutput("nr_cov_data", cov_data, 64'(i) * 64'h100);
      tick(1);
      checkOutput("nr_h_cov_valid", cov_valid, 0);
      checkOutput("nr_h_load_req", load_req, 0);
      checkOutput("nr_h_core_reset", core_reset, 1);
      checkOutput("nr_h_cycle", cycle_cnt, 0);
      tick(RESET_HOLD - 1);
      checkOutput("nr_h_last", core_reset, 1);
      checkOutput("nr_h_last_load_req", load_req, 0);
      tick(1);
      checkOutput("nr_run_core_reset", core_reset, 0);
      checkOutput("nr_iter", iter_cnt, 64'(i));
    end

    $display("[TB] reset during load");
    applyStimulus(64'h1, 1'b1, 64'd0, 64'h9, 1'b1, 1'b1, 1'b0);
    tick(1);
    tohost = 64'h0;
    tick(1);
    checkOutput("rl_report", cov_valid, 1);
    tick(1);
    checkOutput("rl_load_req", load_req, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    cov_ready  = 1'b0;
    cov_reload = 1'b0;
    checkOutput("rl_load_req_drop", load_req, 0);
    checkOutput("rl_cov_valid", cov_valid, 0);
    checkOutput("rl_core_reset", core_reset, 1);
    checkOutput("rl_iter", iter_cnt, 0);
    tick(RESET_HOLD - 1);
    checkOutput("rl_init_last", core_reset, 1);
    tick(1);
    checkOutput("rl_run", core_reset, 0);
    checkOutput("rl_run_iter", iter_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
